fetch_ifid: RTL and testbench
=============================

# fetch_ifid

Instruction-fetch stage and IF/ID pipeline register for the non-forwarding pipeline. It holds the PC and issues requests to a variable-latency instruction memory. It applies the hazard unit's controls (pc_wren, wren_ifid, clear_ifid) and the EX/MEM branch redirect. The IF/ID outputs, including the rs1/rs2 fields, feed the decode stage and the hazard detection unit.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP, 32'h0000_0013, instruction word inserted as a bubble (addi x0,x0,0)

- i_clk  in  1  clock; all state updates on rising edge
- i_reset  in  1  synchronous, active-high reset
- pc_wren  in  1  hazard unit: 1 = PC may advance, 0 = hold PC
- wren_ifid  in  1  hazard unit: 1 = IF/ID may load, 0 = hold IF/ID
- clear_ifid  in  1  hazard unit: flush IF/ID to bubble
- pcsel_exmem  in  1  branch/jump taken, from EX/MEM
- is_br_exmem  in  1  EX/MEM holds a conditional branch
- is_uncbr_exmem  in  1  EX/MEM holds jal/jalr
- alu_data_exmem  in  32  redirect target
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address; word-aligned
- imem_ack  in  1  response valid; counted only while imem_req=1
- imem_rdata  in  32  instruction word, valid with imem_ack
- pc_ifid  out  32  PC of IF/ID instruction
- pc4_ifid  out  32  pc_ifid + 4
- instr_ifid  out  32  IF/ID instruction
- valid_ifid  out  1  1 = real instruction, 0 = bubble
- rs1_ifid  out  5  instr_ifid[19:15]; 0 when bubble
- rs2_ifid  out  5  instr_ifid[24:20]; 0 when bubble

## Operation
- redirect = pcsel_exmem & (is_br_exmem | is_uncbr_exmem).
- redirect has priority over the stall controls.
- accept = wren_ifid & pc_wren & ~redirect.
- Handshake: once imem_req=1, imem_addr stays stable until imem_ack.
- imem_ack may arrive in the same cycle as the request (zero wait).
- Responses arrive in order, one per request.
- FSM states: FETCH, HOLD, DRAIN.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On ack & accept: IF/ID <= {pc, imem_rdata, valid=1}; pc <= pc+4; stay FETCH.
  - On ack & ~accept & ~redirect: imem_rdata -> hold buffer (with pc); go HOLD; PC holds.
  - On redirect with ack: data dropped; pc <= alu_data_exmem; stay FETCH.
  - On redirect without ack: pc <= alu_data_exmem; go DRAIN.
- HOLD:
  - imem_req=0.
  - On accept: IF/ID <= buffer; pc <= pc+4; go FETCH.
  - On redirect: buffer discarded; pc <= target; go FETCH.
- DRAIN:
  - imem_req=1 with the pre-redirect address.
  - On ack: response dropped; go FETCH (new pc).
  - A further redirect updates pc and stays in DRAIN.
- IF/ID update priority, highest first:
  1. clear_ifid or redirect: bubble.
  2. ~wren_ifid: hold.
  3. Instruction delivered: load.
  4. wren_ifid with nothing delivered: bubble.
- Bubble: instr=NOP, valid=0, rs1/rs2=0, pc_ifid=0, pc4_ifid=4.
- PC arithmetic is 32-bit and wraps: 32'hFFFF_FFFC + 4 = 0.
- Redirect target bits [1:0] are forced to 0.

## Timing
- Reset values:
  - pc=RESET_PC, state=FETCH, imem_req=0 during reset, buffer empty.
  - instr_ifid=NOP, valid_ifid=0, pc_ifid=0, pc4_ifid=4, rs1/rs2=0.
- First cycle after reset: imem_req=1, imem_addr=RESET_PC.
- Zero-wait memory: one instruction per cycle. Ack in cycle n puts the instruction on IF/ID outputs after edge n.
- N-cycle memory: N-1 bubbles inserted per fetch.
- Redirect sampled at edge n: fetch of target starts cycle n+1 (after DRAIN completes, if entered). IF/ID is a bubble after edge n.
- Reset mid-DRAIN or mid-request abandons the transaction. The instruction memory shares i_reset and drops pending requests.
- clear_ifid together with ack & accept: instruction still consumed (PC advances), IF/ID gets bubble.
- clear_ifid with ~wren_ifid: clear wins.

## Test plan
- Reset, zero-wait memory returning 32'h0000_0093 at every address -> imem_addr 0,4,8,12 on consecutive cycles; pc_ifid 0,4,8 one cycle later; valid_ifid=1.
- 3-cycle ack latency -> imem_addr stable 3 cycles; two bubbles (instr_ifid=NOP, valid=0) between each valid instruction.
- Stall (pc_wren=0, wren_ifid=0) for 2 cycles, ack arrives in the first cycle -> HOLD, imem_req=0. After release the buffered word appears at IF/ID with the correct pc; no refetch.
- Redirect to 32'h0000_0100 while a request to 0x8 is pending (ack 2 cycles later) -> DRAIN holds addr 0x8 until ack; data dropped; next request addr 0x100; IF/ID bubble.
- Redirect in the same cycle as ack & accept -> fetched word dropped; IF/ID bubble; next imem_addr equals the target. clear_ifid alone -> bubble, PC still advances.
- PC at 32'hFFFF_FFFC accepted -> next imem_addr 0. Reset asserted mid-wait -> next cycle after deassertion, imem_addr=RESET_PC and IF/ID outputs at reset values.

Source files
------------

// File: rtl/fetch_ifid_if.sv
// Instruction-memory request/response bus between the fetch stage and the imem.
interface fetch_ifid_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
   modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_ifid.sv
// Instruction fetch with variable-latency imem handshake and the IF/ID pipeline register.
module fetch_ifid #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP      = 32'h0000_0013
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          pc_wren,
   input  logic          wren_ifid,
   input  logic          clear_ifid,
   input  logic          pcsel_exmem,
   input  logic          is_br_exmem,
   input  logic          is_uncbr_exmem,
   input  logic [31:0]   alu_data_exmem,
   fetch_ifid_if.master  imem,
   output logic [31:0]   pc_ifid,
   output logic [31:0]   pc4_ifid,
   output logic [31:0]   instr_ifid,
   output logic          valid_ifid,
   output logic [4:0]    rs1_ifid,
   output logic [4:0]    rs2_ifid
);

   typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_e;

   state_e      state_q;
   logic [31:0] pc_q;
   logic [31:0] addr_q;
   logic        req_q;
   logic [31:0] buf_q;

   logic [31:0] if_pc_q, if_pc4_q, if_instr_q;
   logic        if_vld_q;
   logic [4:0]  if_rs1_q, if_rs2_q;
   logic [31:0] if_pc_d, if_pc4_d, if_instr_d;
   logic        if_vld_d;
   logic [4:0]  if_rs1_d, if_rs2_d;

   logic        redirect, accept, ack_v, deliver;
   logic [31:0] tgt, pc_inc, dlv_word;
   logic        unused_tgt_lsb;

   assign redirect       = pcsel_exmem & (is_br_exmem | is_uncbr_exmem);
   assign accept         = wren_ifid & pc_wren & ~redirect;
   assign tgt            = {alu_data_exmem[31:2], 2'b00};
   assign unused_tgt_lsb = ^alu_data_exmem[1:0];
   assign pc_inc         = pc_q + 32'd4;

   // The memory shares i_reset, so the request is masked while reset is held.
   assign imem.imem_req  = req_q & ~i_reset;
   assign imem.imem_addr = addr_q;
   assign ack_v          = imem.imem_ack & imem.imem_req;

   // PC holds while buffered, so pc_q is also the PC of the buffered word.
   assign deliver  = accept & (((state_q == FETCH) & ack_v) | (state_q == HOLD));
   assign dlv_word = (state_q == HOLD) ? buf_q : imem.imem_rdata;

   always_comb begin
      if_pc_d    = if_pc_q;
      if_pc4_d   = if_pc4_q;
      if_instr_d = if_instr_q;
      if_vld_d   = if_vld_q;
      if_rs1_d   = if_rs1_q;
      if_rs2_d   = if_rs2_q;
      if (clear_ifid | redirect | (wren_ifid & ~deliver)) begin
         if_pc_d    = 32'd0;
         if_pc4_d   = 32'd4;
         if_instr_d = NOP;
         if_vld_d   = 1'b0;
         if_rs1_d   = 5'd0;
         if_rs2_d   = 5'd0;
      end else if (wren_ifid) begin
         if_pc_d    = pc_q;
         if_pc4_d   = pc_inc;
         if_instr_d = dlv_word;
         if_vld_d   = 1'b1;
         if_rs1_d   = dlv_word[19:15];
         if_rs2_d   = dlv_word[24:20];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q    <= FETCH;
         pc_q       <= RESET_PC;
         addr_q     <= RESET_PC;
         req_q      <= 1'b1;
         buf_q      <= NOP;
         if_pc_q    <= 32'd0;
         if_pc4_q   <= 32'd4;
         if_instr_q <= NOP;
         if_vld_q   <= 1'b0;
         if_rs1_q   <= 5'd0;
         if_rs2_q   <= 5'd0;
      end else begin
         if_pc_q    <= if_pc_d;
         if_pc4_q   <= if_pc4_d;
         if_instr_q <= if_instr_d;
         if_vld_q   <= if_vld_d;
         if_rs1_q   <= if_rs1_d;
         if_rs2_q   <= if_rs2_d;
         case (state_q)
            FETCH: begin
               if (redirect) begin
                  pc_q <= tgt;
                  // Without an ack the old request stays on the bus until it drains.
                  if (ack_v) addr_q  <= tgt;
                  else       state_q <= DRAIN;
               end else if (ack_v) begin
                  if (accept) begin
                     pc_q   <= pc_inc;
                     addr_q <= pc_inc;
                  end else begin
                     buf_q   <= imem.imem_rdata;
                     state_q <= HOLD;
                     req_q   <= 1'b0;
                  end
               end
            end
            HOLD: begin
               if (redirect) begin
                  pc_q    <= tgt;
                  addr_q  <= tgt;
                  state_q <= FETCH;
                  req_q   <= 1'b1;
               end else if (accept) begin
                  pc_q    <= pc_inc;
                  addr_q  <= pc_inc;
                  state_q <= FETCH;
                  req_q   <= 1'b1;
               end
            end
            DRAIN: begin
               if (redirect) pc_q <= tgt;
               if (ack_v) begin
                  state_q <= FETCH;
                  addr_q  <= redirect ? tgt : pc_q;
               end
            end
            default: begin
               state_q <= FETCH;
               req_q   <= 1'b1;
               addr_q  <= pc_q;
            end
         endcase
      end
   end

   assign pc_ifid    = if_pc_q;
   assign pc4_ifid   = if_pc4_q;
   assign instr_ifid = if_instr_q;
   assign valid_ifid = if_vld_q;
   assign rs1_ifid   = if_rs1_q;
   assign rs2_ifid   = if_rs2_q;

endmodule

// File: tb/tb_fetch_ifid.sv
// Bench for fetch_ifid: vector table, directed multi-cycle sequences, random run vs reference model.
module tb_fetch_ifid;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        pc_wren, wren_ifid, clear_ifid, pcsel_exmem, is_br_exmem, is_uncbr_exmem;
   logic [31:0] alu_data_exmem;
   logic [31:0] pc_ifid, pc4_ifid, instr_ifid;
   logic        valid_ifid;
   logic [4:0]  rs1_ifid, rs2_ifid;

   fetch_ifid_if bus();

   fetch_ifid dut (
      .i_clk(i_clk), .i_reset(i_reset), .pc_wren(pc_wren), .wren_ifid(wren_ifid),
      .clear_ifid(clear_ifid), .pcsel_exmem(pcsel_exmem), .is_br_exmem(is_br_exmem),
      .is_uncbr_exmem(is_uncbr_exmem), .alu_data_exmem(alu_data_exmem), .imem(bus),
      .pc_ifid(pc_ifid), .pc4_ifid(pc4_ifid), .instr_ifid(instr_ifid),
      .valid_ifid(valid_ifid), .rs1_ifid(rs1_ifid), .rs2_ifid(rs2_ifid)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int errors = 0;

   // Instruction memory: waits cnt cycles per request, in order, drops on reset.
   logic w93 = 1'b1;
   logic rnd_lat = 1'b0;
   int   lat_fix = 0;
   int   lat_cur = 0;
   int   cnt = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a, input logic k93);
      return k93 ? 32'h0000_0093 : ((a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]});
   endfunction

   assign bus.imem_rdata = mem_word(bus.imem_addr, w93);
   assign bus.imem_ack   = bus.imem_req && (cnt >= (rnd_lat ? lat_cur : lat_fix));

   always @(posedge i_clk) begin
      if (i_reset) cnt <= 0;
      else if (bus.imem_req && bus.imem_ack) begin
         cnt     <= 0;
         lat_cur <= int'($urandom_range(0, 3));
      end else if (bus.imem_req) cnt <= cnt + 1;
   end

   // Reference model: fetch pointer, optional buffered word, optional response to discard.
   logic [31:0] m_pc = 0, m_bw = 0, m_daddr = 0;
   logic        m_buf = 0, m_drain = 0;
   logic        m_ifvld = 0;
   logic [31:0] m_ifpc = 0, m_ifinstr = NOP;

   task automatic model_step();
      logic r, a, ack, have_w;
      logic [31:0] t, w, wpc;
      r = pcsel_exmem & (is_br_exmem | is_uncbr_exmem);
      a = wren_ifid & pc_wren & ~r;
      t = alu_data_exmem & 32'hFFFF_FFFC;
      ack = bus.imem_ack & bus.imem_req;
      have_w = 0; w = 0; wpc = 0;
      if (i_reset) begin
         m_pc = 0; m_buf = 0; m_drain = 0; m_ifvld = 0; m_ifpc = 0; m_ifinstr = NOP;
         return;
      end
      if (m_buf) begin
         if (r) begin m_buf = 0; m_pc = t; end
         else if (a) begin have_w = 1; w = m_bw; wpc = m_pc; m_pc = m_pc + 4; m_buf = 0; end
      end else if (m_drain) begin
         if (r) m_pc = t;
         if (ack) m_drain = 0;
      end else if (ack) begin
         if (r) m_pc = t;
         else if (a) begin have_w = 1; w = bus.imem_rdata; wpc = m_pc; m_pc = m_pc + 4; end
         else begin m_buf = 1; m_bw = bus.imem_rdata; end
      end else if (r) begin
         m_drain = 1; m_daddr = m_pc; m_pc = t;
      end
      if (clear_ifid | r) begin m_ifvld = 0; m_ifpc = 0; m_ifinstr = NOP; end
      else if (!wren_ifid) ;
      else if (have_w) begin m_ifvld = 1; m_ifpc = wpc; m_ifinstr = w; end
      else begin m_ifvld = 0; m_ifpc = 0; m_ifinstr = NOP; end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic chk_ifid(input string nm, input logic vld, input logic [31:0] pc,
                           input logic [31:0] ins);
      logic [31:0] epc, ein;
      epc = vld ? pc : 32'd0;
      ein = vld ? ins : NOP;
      chk({nm, ".pc"},    pc_ifid, epc);
      chk({nm, ".pc4"},   pc4_ifid, epc + 32'd4);
      chk({nm, ".instr"}, instr_ifid, ein);
      chk({nm, ".valid"}, {31'd0, valid_ifid}, {31'd0, vld});
      chk({nm, ".rs1"},   {27'd0, rs1_ifid}, vld ? {27'd0, ein[19:15]} : 32'd0);
      chk({nm, ".rs2"},   {27'd0, rs2_ifid}, vld ? {27'd0, ein[24:20]} : 32'd0);
   endtask

   task automatic drive(input logic pcw, input logic wr, input logic clr, input logic sel,
                        input logic br, input logic unc, input logic [31:0] tgt);
      pc_wren = pcw; wren_ifid = wr; clear_ifid = clr;
      pcsel_exmem = sel; is_br_exmem = br; is_uncbr_exmem = unc; alu_data_exmem = tgt;
   endtask

   task automatic tick();
      #1;
      model_step();
      @(posedge i_clk);
      @(negedge i_clk);
   endtask

   typedef struct {
      logic pcw, wr, clr, sel, br, unc;
      logic [31:0] tgt;
      logic ereq;
      logic [31:0] eaddr;
      logic evld;
      logic [31:0] epc;
   } vec_t;

   function automatic vec_t mkv(input logic pcw, input logic wr, input logic clr,
                                input logic sel, input logic br, input logic unc,
                                input logic [31:0] tgt, input logic ereq,
                                input logic [31:0] eaddr, input logic evld,
                                input logic [31:0] epc);
      vec_t v;
      v.pcw = pcw; v.wr = wr; v.clr = clr; v.sel = sel; v.br = br; v.unc = unc;
      v.tgt = tgt; v.ereq = ereq; v.eaddr = eaddr; v.evld = evld; v.epc = epc;
      return v;
   endfunction

   vec_t tbl [16];

   initial begin
      tbl[0]  = mkv(1,1,0, 0,0,0, 0,          1, 32'h004, 1, 32'h000);
      tbl[1]  = mkv(1,1,0, 0,0,0, 0,          1, 32'h008, 1, 32'h004);
      tbl[2]  = mkv(1,1,0, 0,0,0, 0,          1, 32'h00C, 1, 32'h008);
      tbl[3]  = mkv(1,1,1, 0,0,0, 0,          1, 32'h010, 0, 32'h000);
      tbl[4]  = mkv(1,1,0, 0,0,0, 0,          1, 32'h014, 1, 32'h010);
      tbl[5]  = mkv(0,0,0, 0,0,0, 0,          0, 32'h000, 1, 32'h010);
      tbl[6]  = mkv(0,0,0, 0,0,0, 0,          0, 32'h000, 1, 32'h010);
      tbl[7]  = mkv(1,1,0, 0,0,0, 0,          1, 32'h018, 1, 32'h014);
      tbl[8]  = mkv(1,1,0, 0,0,0, 0,          1, 32'h01C, 1, 32'h018);
      tbl[9]  = mkv(1,1,0, 1,1,0, 32'h103,    1, 32'h100, 0, 32'h000);
      tbl[10] = mkv(1,1,0, 0,0,0, 0,          1, 32'h104, 1, 32'h100);
      tbl[11] = mkv(0,1,0, 0,0,0, 0,          0, 32'h000, 0, 32'h000);
      tbl[12] = mkv(1,1,0, 1,0,0, 32'h300,    1, 32'h108, 1, 32'h104);
      tbl[13] = mkv(0,0,1, 0,0,0, 0,          0, 32'h000, 0, 32'h000);
      tbl[14] = mkv(0,0,0, 1,0,1, 32'h200,    1, 32'h200, 0, 32'h000);
      tbl[15] = mkv(1,1,0, 0,0,0, 0,          1, 32'h204, 1, 32'h200);

      drive(1,1,0,0,0,0,0);
      tick(); tick();
      chk("rst.req", {31'd0, bus.imem_req}, 32'd0);
      chk_ifid("rst", 1'b0, 32'd0, NOP);
      i_reset = 1'b0;
      #1;
      chk("first.req", {31'd0, bus.imem_req}, 32'd1);
      chk("first.addr", bus.imem_addr, 32'd0);

      // Zero-wait stream with clear, stall, redirect and hold cases.
      for (int i = 0; i < 16; i++) begin
         drive(tbl[i].pcw, tbl[i].wr, tbl[i].clr, tbl[i].sel, tbl[i].br, tbl[i].unc, tbl[i].tgt);
         tick();
         chk($sformatf("tbl%0d.req", i), {31'd0, bus.imem_req}, {31'd0, tbl[i].ereq});
         if (tbl[i].ereq) chk($sformatf("tbl%0d.addr", i), bus.imem_addr, tbl[i].eaddr);
         chk_ifid($sformatf("tbl%0d", i), tbl[i].evld, tbl[i].epc, 32'h0000_0093);
      end

      // Three-cycle memory: address held three cycles, two bubbles between instructions.
      i_reset = 1'b1; w93 = 1'b0; lat_fix = 2;
      drive(1,1,0,0,0,0,0);
      tick();
      i_reset = 1'b0;
      for (int j = 0; j < 6; j++) begin
         tick();
         chk($sformatf("lat%0d.addr", j), bus.imem_addr, 32'(4 * ((j + 1) / 3)));
         chk_ifid($sformatf("lat%0d", j), (j % 3) == 2, 32'(4 * (j / 3)), mem_word(32'(4 * (j / 3)), 1'b0));
      end

      // Redirect while the request to 0x8 is outstanding.
      drive(1,1,0,1,1,0,32'h100);
      tick();
      chk("drn0.req", {31'd0, bus.imem_req}, 32'd1);
      chk("drn0.addr", bus.imem_addr, 32'h8);
      chk_ifid("drn0", 1'b0, 0, 0);
      drive(1,1,0,0,0,0,0);
      tick();
      chk("drn1.addr", bus.imem_addr, 32'h8);
      chk_ifid("drn1", 1'b0, 0, 0);
      tick();
      chk("drn2.addr", bus.imem_addr, 32'h100);
      chk_ifid("drn2", 1'b0, 0, 0);
      tick(); tick();
      chk_ifid("drn3", 1'b0, 0, 0);
      tick();
      chk("drn4.addr", bus.imem_addr, 32'h104);
      chk_ifid("drn4", 1'b1, 32'h100, mem_word(32'h100, 1'b0));

      // PC wrap at the top of the address space.
      lat_fix = 0;
      drive(1,1,0,1,0,1,32'hFFFF_FFFE);
      tick();
      chk("wrap0.addr", bus.imem_addr, 32'hFFFF_FFFC);
      drive(1,1,0,0,0,0,0);
      tick();
      chk("wrap1.addr", bus.imem_addr, 32'h0);
      chk("wrap1.pc4", pc4_ifid, 32'h0);
      chk_ifid("wrap1", 1'b1, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC, 1'b0));

      // Reset while a slow request is pending.
      lat_fix = 3;
      tick(); tick();
      i_reset = 1'b1;
      tick();
      chk("rstw.req", {31'd0, bus.imem_req}, 32'd0);
      chk_ifid("rstw", 1'b0, 0, 0);
      i_reset = 1'b0;
      #1;
      chk("rstw1.req", {31'd0, bus.imem_req}, 32'd1);
      chk("rstw1.addr", bus.imem_addr, 32'h0);

      // Random traffic against the model.
      rnd_lat = 1'b1;
      i_reset = 1'b1;
      tick();
      for (int n = 0; n < 4000; n++) begin
         i_reset = ($urandom_range(0, 99) == 0);
         drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0,
               $urandom_range(0, 6) == 0, 1'($urandom), 1'($urandom), $urandom);
         tick();
         chk("rnd.req", {31'd0, bus.imem_req}, {31'd0, ~m_buf & ~i_reset});
         if (~m_buf & ~i_reset) chk("rnd.addr", bus.imem_addr, m_drain ? m_daddr : m_pc);
         chk_ifid("rnd", m_ifvld, m_ifpc, m_ifinstr);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
